// File: rtl/lift_pkg.sv
// lift_pkg: shared definitions for the three-floor lift controller.
//   NUM_REQ      number of request bits (hall calls + cabin calls)
//   REQ_*        bit index of each request inside the request/clear vectors
//   floor_e      floor enumeration shared with the lift state machine
package lift_pkg;

  localparam int NUM_REQ = 7;

  // Fixed bit order used for buttons, requests and clear strobes alike.
  localparam int REQ_UP0 = 0;
  localparam int REQ_UP1 = 1;
  localparam int REQ_DN1 = 2;
  localparam int REQ_DN2 = 3;
  localparam int REQ_FL0 = 4;
  localparam int REQ_FL1 = 5;
  localparam int REQ_FL2 = 6;

  typedef enum logic [1:0] {
    GND = 2'd0,
    ONE = 2'd1,
    TWO = 2'd2
  } floor_e;

endpackage

// File: rtl/lift_debounce.sv
// lift_debounce: two-flop synchroniser plus slow-tick debouncer for one button.
//   clk        system clock
//   reset      synchronous active-high reset
//   slowref_i  one-cycle clock-enable tick; debounce only advances on it
//   btn_i      raw asynchronous button level
//   deb_o      accepted (debounced) level, registered
// A changed level must be seen on DEB_TICKS consecutive ticks before it is
// accepted; any tick that sees the accepted level again restarts the count.
module lift_debounce #(
  parameter int DEB_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic slowref_i,
  input  logic btn_i,
  output logic deb_o
);

  logic       sync1_q, sync2_q;
  logic       deb_q,   deb_d;
  logic [3:0] dcnt_q,  dcnt_d;
  logic [3:0] dcnt_inc;

  assign dcnt_inc = dcnt_q + 4'd1;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (slowref_i) begin
      if (sync2_q != deb_q) begin
        if (dcnt_inc == 4'(DEB_TICKS)) begin
          deb_d  = sync2_q;
          dcnt_d = 4'd0;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end else begin
        dcnt_d = 4'd0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the sync chain depends on this to stay two stages deep.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      dcnt_q  <= 4'd0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/lift_req.sv
// lift_req: request front end for the three-floor lift controller.
//   clk, reset                  system clock, synchronous active-high reset
//   btn_up0/up1/dn1/dn2         raw hall-call buttons
//   btn_fl0/fl1/fl2             raw cabin buttons
//   clr_flreq0..2, clrup0/1,
//   clrdn1/2                    clear strobes from the lift state machine
//   slowref                     one-cycle enable tick every DIV cycles
//   upreq0/1, dnreq1/2,
//   flreq0..2                   registered sticky requests
// Each button is debounced on slowref ticks; a debounced rising edge sets its
// request, which stays set until a slowref-qualified clear arrives.
module lift_req
  import lift_pkg::*;
#(
  parameter int DIV       = 1000,
  parameter int DEB_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up0,
  input  logic btn_up1,
  input  logic btn_dn1,
  input  logic btn_dn2,
  input  logic btn_fl0,
  input  logic btn_fl1,
  input  logic btn_fl2,
  input  logic clr_flreq0,
  input  logic clr_flreq1,
  input  logic clr_flreq2,
  input  logic clrup0,
  input  logic clrup1,
  input  logic clrdn1,
  input  logic clrdn2,
  output logic slowref,
  output logic upreq0,
  output logic upreq1,
  output logic dnreq1,
  output logic dnreq2,
  output logic flreq0,
  output logic flreq1,
  output logic flreq2
);

  localparam int                 CNT_W   = $clog2(DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DIV - 1);

  // ---------------------------------------------------------------- prescaler
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slowref_q, slowref_d;

  always_comb begin
    cnt_d     = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    slowref_d = (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      slowref_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      slowref_q <= slowref_d;
    end
  end

  assign slowref = slowref_q;

  // ---------------------------------------------------- button/clear vectors
  logic [NUM_REQ-1:0] btn_v, clr_v;

  always_comb begin
    btn_v          = '0;
    btn_v[REQ_UP0] = btn_up0;
    btn_v[REQ_UP1] = btn_up1;
    btn_v[REQ_DN1] = btn_dn1;
    btn_v[REQ_DN2] = btn_dn2;
    btn_v[REQ_FL0] = btn_fl0;
    btn_v[REQ_FL1] = btn_fl1;
    btn_v[REQ_FL2] = btn_fl2;

    clr_v          = '0;
    clr_v[REQ_UP0] = clrup0;
    clr_v[REQ_UP1] = clrup1;
    clr_v[REQ_DN1] = clrdn1;
    clr_v[REQ_DN2] = clrdn2;
    clr_v[REQ_FL0] = clr_flreq0;
    clr_v[REQ_FL1] = clr_flreq1;
    clr_v[REQ_FL2] = clr_flreq2;
  end

  // ------------------------------------------------------------- debouncers
  logic [NUM_REQ-1:0] deb_v;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_deb
    lift_debounce #(
      .DEB_TICKS(DEB_TICKS)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .slowref_i(slowref_q),
      .btn_i    (btn_v[i]),
      .deb_o    (deb_v[i])
    );
  end

  // ------------------------------------------------- edge detect + requests
  logic [NUM_REQ-1:0] deb_prev_q;
  logic [NUM_REQ-1:0] req_q, req_d;
  logic [NUM_REQ-1:0] set_v, clr_en_v;

  always_comb begin
    // A held button produces a single rising edge, so it sets only once.
    set_v    = deb_v & ~deb_prev_q;
    // The state machine holds its clear until its own slowref edge, so the
    // clear is only honoured there; the request must stay up until then.
    clr_en_v = clr_v & {NUM_REQ{slowref_q}};
    // NOTE: set is OR-ed in after the clear mask, so a coincident set wins.
    req_d    = set_v | (req_q & ~clr_en_v);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_prev_q <= '0;
      req_q      <= '0;
    end else begin
      deb_prev_q <= deb_v;
      req_q      <= req_d;
    end
  end

  assign upreq0 = req_q[REQ_UP0];
  assign upreq1 = req_q[REQ_UP1];
  assign dnreq1 = req_q[REQ_DN1];
  assign dnreq2 = req_q[REQ_DN2];
  assign flreq0 = req_q[REQ_FL0];
  assign flreq1 = req_q[REQ_FL1];
  assign flreq2 = req_q[REQ_FL2];

endmodule
